// File: rtl/ifu_if.sv
// Instruction-memory read port between the fetch unit and instruction memory.
//   req    : one-cycle read request (master -> slave)
//   addr   : read address, valid while req is high (master -> slave)
//   rvalid : read data valid (slave -> master)
//   rdata  : read data (slave -> master)
interface ifu_if #(
    parameter int unsigned CPU_WIDTH = 32
);
    logic                 req;
    logic [CPU_WIDTH-1:0] addr;
    logic                 rvalid;
    logic [CPU_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit for the single-issue multi-cycle core.
// Owns the architectural PC, issues one instruction-memory read per
// instruction, holds the returned word for decode/branch, and loads the
// branch unit's next PC when the core commits the held instruction.
//
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_bru_next_pc    : next PC from the branch unit, sampled on commit
//   i_exu_commit     : one-cycle retire pulse for the held instruction
//   imem             : instruction-memory read port (master side)
//   o_ifu_pc         : PC of the instruction being fetched or held
//   o_ifu_inst       : held instruction word
//   o_ifu_valid      : o_ifu_inst is valid for o_ifu_pc
//   o_ifu_misalign   : sticky flag, a committed next PC was not word aligned
//   o_ifu_inst_cnt   : retired-instruction count, wraps
module ifu #(
    parameter int unsigned         CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC = CPU_WIDTH'(32'h8000_0000)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CPU_WIDTH-1:0] i_bru_next_pc,
    input  logic                 i_exu_commit,
    ifu_if.master                imem,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic [CPU_WIDTH-1:0] o_ifu_inst,
    output logic                 o_ifu_valid,
    output logic                 o_ifu_misalign,
    output logic [CPU_WIDTH-1:0] o_ifu_inst_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t state_q;

    logic next_pc_misaligned;
    assign next_pc_misaligned = (i_bru_next_pc[1:0] != 2'b00);

    // Request is a decode of the FETCH state; masked while reset is held so
    // nothing is issued to memory during reset.
    assign imem.req  = (state_q == S_FETCH) && !i_rst;
    assign imem.addr = o_ifu_pc;

    // Fetch sequencer with all architectural outputs registered alongside it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_FETCH;
            o_ifu_pc       <= RESET_PC;
            o_ifu_inst     <= '0;
            o_ifu_valid    <= 1'b0;
            o_ifu_misalign <= 1'b0;
            o_ifu_inst_cnt <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // Memory always accepts the request.
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (imem.rvalid) begin
                        o_ifu_inst  <= imem.rdata;
                        o_ifu_valid <= 1'b1;
                        state_q     <= S_VALID;
                    end
                end

                S_VALID: begin
                    if (i_exu_commit) begin
                        o_ifu_pc       <= i_bru_next_pc;
                        o_ifu_inst_cnt <= o_ifu_inst_cnt + CPU_WIDTH'(1);
                        o_ifu_valid    <= 1'b0;
                        if (next_pc_misaligned) begin
                            o_ifu_misalign <= 1'b1;
                            state_q        <= S_HALT;
                        end else begin
                            state_q        <= S_FETCH;
                        end
                    end
                end

                S_HALT: begin
                    // Parked with the offending PC visible; only reset leaves.
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a per-cycle vector table for the main flows plus
// hand-written sequences for protocol invariants and counter wrap.
module tb_ifu;

    localparam logic [31:0] R = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 32-bit instance.
    logic        rst;
    logic [31:0] npc;
    logic        commit;
    logic [31:0] pc, inst, cnt;
    logic        valid, mis;

    ifu_if #(.CPU_WIDTH(32)) m_if ();

    ifu #(.CPU_WIDTH(32), .RESET_PC(R)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bru_next_pc  (npc),
        .i_exu_commit   (commit),
        .imem           (m_if),
        .o_ifu_pc       (pc),
        .o_ifu_inst     (inst),
        .o_ifu_valid    (valid),
        .o_ifu_misalign (mis),
        .o_ifu_inst_cnt (cnt)
    );

    // Narrow instance so the retire counter wrap is reachable quickly.
    logic       s_rst;
    logic [3:0] s_pc, s_inst, s_cnt;
    logic       s_valid, s_mis;

    ifu_if #(.CPU_WIDTH(4)) s_if ();

    ifu #(.CPU_WIDTH(4), .RESET_PC(4'h0)) dut_s (
        .i_clk          (clk),
        .i_rst          (s_rst),
        .i_bru_next_pc  (4'h0),
        .i_exu_commit   (1'b1),
        .imem           (s_if),
        .o_ifu_pc       (s_pc),
        .o_ifu_inst     (s_inst),
        .o_ifu_valid    (s_valid),
        .o_ifu_misalign (s_mis),
        .o_ifu_inst_cnt (s_cnt)
    );

    assign s_if.rvalid = 1'b1;
    assign s_if.rdata  = 4'h3;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariants: req never with valid, req never two cycles running.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("req_and_valid", 0, 32'(m_if.req && valid), 32'd0);
            check("req_back_to_back", 0, 32'(m_if.req && req_prev), 32'd0);
        end
        req_prev <= m_if.req;
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rdata;
        logic        cm;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic rv, input logic [31:0] rd,
                                input logic cm, input logic [31:0] np,
                                input logic e_req, input logic [31:0] e_pc,
                                input logic [31:0] e_inst, input logic e_valid,
                                input logic e_mis, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = r; v.rv = rv; v.rdata = rd; v.cm = cm; v.npc = np;
        v.e_req = e_req; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_valid = e_valid; v.e_mis = e_mis; v.e_cnt = e_cnt;
        vt.push_back(v);
    endfunction

    initial begin
        int waited;

        // Row = inputs driven during a cycle, expected outputs in that cycle.
        //   rst rv rdata          cm npc              | req pc        inst           v  mis cnt
        // Zero-latency memory; commit held off one cycle so next req is cycle 4.
        add(0, 0, 32'h0,          0, 32'h0,          1, R,          32'h0,         0, 0, 0);  // c0 FETCH
        add(0, 1, 32'h0000_0013,  0, 32'h0,          0, R,          32'h0,         0, 0, 0);  // c1 WAIT
        add(0, 0, 32'h0,          0, 32'h0,          0, R,          32'h13,        1, 0, 0);  // c2 VALID
        add(0, 0, 32'h0,          1, R + 32'h4,      0, R,          32'h13,        1, 0, 0);  // c3 commit
        // Commit in FETCH is ignored.
        add(0, 0, 32'h0,          1, 32'hDEAD_BEE0,  1, R + 32'h4,  32'h13,        0, 0, 1);  // c4 FETCH
        // 5-cycle memory latency, commit in WAIT ignored.
        add(0, 0, 32'h0,          0, 32'h0,          0, R + 32'h4,  32'h13,        0, 0, 1);  // c5
        add(0, 0, 32'h0,          1, 32'h1234_5678,  0, R + 32'h4,  32'h13,        0, 0, 1);  // c6
        add(0, 0, 32'h0,          0, 32'h0,          0, R + 32'h4,  32'h13,        0, 0, 1);  // c7
        add(0, 0, 32'h0,          0, 32'h0,          0, R + 32'h4,  32'h13,        0, 0, 1);  // c8
        add(0, 1, 32'h0010_0093,  0, 32'h0,          0, R + 32'h4,  32'h13,        0, 0, 1);  // c9 data
        // Spurious rvalid in VALID leaves the held word alone.
        add(0, 1, 32'hFFFF_FFFF,  0, 32'h0,          0, R + 32'h4,  32'h0010_0093, 1, 0, 1);  // c10
        add(0, 1, 32'hAAAA_AAAA,  0, 32'h0,          0, R + 32'h4,  32'h0010_0093, 1, 0, 1);  // c11
        add(0, 0, 32'h0,          1, R + 32'h8,      0, R + 32'h4,  32'h0010_0093, 1, 0, 1);  // c12 commit
        // Spurious rvalid in FETCH is ignored too.
        add(0, 1, 32'h5555_5555,  0, 32'h0,          1, R + 32'h8,  32'h0010_0093, 0, 0, 2);  // c13 FETCH
        add(0, 1, 32'h0000_0513,  0, 32'h0,          0, R + 32'h8,  32'h0010_0093, 0, 0, 2);  // c14 WAIT
        // Misaligned next PC parks in HALT.
        add(0, 0, 32'h0,          1, R + 32'h102,    0, R + 32'h8,  32'h513,       1, 0, 2);  // c15 commit
        add(0, 1, 32'h1111_1111,  1, R + 32'h200,    0, R + 32'h102, 32'h513,      0, 1, 3);  // c16 HALT
        add(0, 0, 32'h0,          1, R + 32'h300,    0, R + 32'h102, 32'h513,      0, 1, 3);  // c17 HALT
        add(1, 0, 32'h0,          0, 32'h0,          0, R + 32'h102, 32'h513,      0, 1, 3);  // c18 reset
        add(0, 0, 32'h0,          0, 32'h0,          1, R,          32'h0,         0, 0, 0);  // c19 FETCH
        // One good instruction, then reset lands mid-WAIT alongside rvalid.
        add(0, 1, 32'h0000_0013,  0, 32'h0,          0, R,          32'h0,         0, 0, 0);  // c20 WAIT
        add(0, 0, 32'h0,          1, R + 32'h10,     0, R,          32'h13,        1, 0, 0);  // c21 commit
        add(0, 0, 32'h0,          0, 32'h0,          1, R + 32'h10, 32'h13,        0, 0, 1);  // c22 FETCH
        add(1, 1, 32'h0000_0099,  1, R + 32'h20,     0, R + 32'h10, 32'h13,        0, 0, 1);  // c23 WAIT+rst
        add(1, 1, 32'h0000_0099,  0, 32'h0,          0, R,          32'h0,         0, 0, 0);  // c24 in reset
        add(0, 0, 32'h0,          0, 32'h0,          1, R,          32'h0,         0, 0, 0);  // c25 FETCH

        rst = 1'b1; s_rst = 1'b1;
        commit = 1'b0; npc = '0;
        m_if.rvalid = 1'b0; m_if.rdata = '0;
        repeat (3) tick();

        // Reset values while reset is held.
        check("rst_req",   0, 32'(m_if.req), 32'd0);
        check("rst_pc",    0, pc,    R);
        check("rst_inst",  0, inst,  32'h0);
        check("rst_valid", 0, 32'(valid), 32'd0);
        check("rst_mis",   0, 32'(mis), 32'd0);
        check("rst_cnt",   0, cnt,   32'h0);

        foreach (vt[i]) begin
            rst         = vt[i].rst;
            m_if.rvalid = vt[i].rv;
            m_if.rdata  = vt[i].rdata;
            commit      = vt[i].cm;
            npc         = vt[i].npc;
            #1;
            check("req",   i, 32'(m_if.req), 32'(vt[i].e_req));
            check("addr",  i, m_if.addr, vt[i].e_pc);
            check("pc",    i, pc,   vt[i].e_pc);
            check("inst",  i, inst, vt[i].e_inst);
            check("valid", i, 32'(valid), 32'(vt[i].e_valid));
            check("mis",   i, 32'(mis), 32'(vt[i].e_mis));
            check("cnt",   i, cnt,  vt[i].e_cnt);
            tick();
        end
        commit = 1'b0; m_if.rvalid = 1'b0;

        // Counter wrap on the narrow instance: always-ready memory and an
        // always-asserted commit retire one instruction every 3 cycles.
        s_rst = 1'b0;
        #1;
        waited = 0;
        while (s_cnt != 4'hF && waited < 100) begin
            tick();
            waited++;
        end
        check("wrap_reach_15", 0, 32'(s_cnt), 32'hF);
        check("wrap_ticks_to_15", 0, 32'(waited), 32'd45);
        check("wrap_req_at_15", 0, 32'(s_if.req), 32'd1);
        check("wrap_addr", 0, 32'(s_if.addr), 32'(s_pc));
        check("wrap_valid", 0, 32'(s_valid), 32'd0);
        check("wrap_inst", 0, 32'(s_inst), 32'h3);

        waited = 0;
        while (s_cnt == 4'hF && waited < 10) begin
            tick();
            waited++;
        end
        check("wrap_period", 0, 32'(waited), 32'd3);
        check("wrap_to_zero", 0, 32'(s_cnt), 32'h0);
        check("wrap_mis", 0, 32'(s_mis), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
